crypto_host_ctrl: RTL and testbench
===================================

Name: crypto_host_ctrl

Overview:
Host-side sequencer driving the 16-bit crypto core's job interface from the processor side. Accepts one encrypt/decrypt request over a valid/ready handshake and resets the core. It then pulses the start signal, waits for the core's data and key done strobes, and returns the captured result over a valid/ready response channel. A watchdog converts a hung core into an error response.

Parameters:
CLR_CYCLES, 2, cycles core_rst_n is held low before each job (1..15)
BGN_CYCLES, 10, cycles core_bgn is held high (1..255)
TIMEOUT, 200, max cycles spent in WAIT before error response (2..65535)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_mode  in  2  2'b01 encrypt, 2'b10 decrypt, others invalid
req_data  in  16  plaintext/ciphertext
req_key  in  16  key
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_data  out  16  result data
resp_key  out  16  final round key from core
resp_err  out  1  1 = invalid mode or timeout
core_rst_n  out  1  core reset, active low
core_bgn  out  1  core start
core_mode  out  2  core cript_or_decript select
core_data  out  16  core data_inbus
core_key  out  16  core key_inbus
core_data_done  in  1  core data-output strobe; core_data_out valid same cycle
core_key_done  in  1  core key-output strobe; core_key_out valid same cycle
core_data_out  in  16  core data_outbus
core_key_out  in  16  core key_outbus
busy  out  1  1 in any state except IDLE
job_count  out  8  successful (err=0) jobs completed, wraps 255->0

Behaviour:
- Reset, sampled at a clock edge while rst=1:
  - state=IDLE; req_ready=1, resp_valid=0, resp_data=0, resp_key=0, resp_err=0.
  - core_rst_n=1, core_bgn=0, core_mode=0, core_data=0, core_key=0.
  - busy=0, job_count=0, watchdog=0, both capture flags=0.
  - Reset mid-job abandons the job with no response and no count.
- Registered outputs only. req_ready=1 exactly when state=IDLE.
- IDLE:
  - On req_valid & req_ready, latch mode, data and key into core_mode, core_data and core_key.
  - These three are held stable until the next accept.
  - If mode is 00 or 11, go to RESP with resp_err=1 and resp_data=resp_key=0; the core is not touched.
  - Otherwise go to CLR.
- CLR: core_rst_n=0 for exactly CLR_CYCLES cycles, then START.
- START:
  - core_bgn=1 for exactly BGN_CYCLES cycles, then WAIT.
  - Clear both capture flags on entry to START.
  - Done strobes arriving during START are honoured, with the same capture rules as WAIT.
- WAIT:
  - Watchdog increments each cycle from 0.
  - On core_data_done with data flag clear: capture core_data_out into resp_data and set the data flag.
  - On core_key_done with key flag clear: capture core_key_out into resp_key and set the key flag.
  - Later repeat strobes are ignored (first capture wins).
  - Both strobes in the same cycle capture both values.
  - When both flags are set (including by strobes this cycle), go to RESP with resp_err=0.
  - Else if the watchdog equals TIMEOUT-1, go to RESP with resp_err=1. resp_data/resp_key keep whatever was captured; uncaptured fields are 0.
  - Completion takes priority over timeout in the same cycle.
- RESP:
  - resp_valid=1; resp_* held stable until resp_valid & resp_ready.
  - On that handshake: return to IDLE; job_count increments if resp_err=0.
  - The next request can be accepted in the cycle after the handshake. There is no req/resp overlap; throughput is one job in flight.
- Latency: request accept to resp_valid is at least 1 + CLR_CYCLES + BGN_CYCLES cycles, plus core time.
- Strobes in IDLE, CLR or RESP are ignored.

Test Plan:
- Encrypt req (mode 01, data 16'h59B3, key 16'h1325); core model strobes data_done with 16'h6A21, then key_done 3 cycles later with 16'hB4C7. Expect:
  - core_rst_n low for exactly 2 cycles, then core_bgn high for exactly 10 cycles.
  - resp_valid with data 6A21, key B4C7, err 0; job_count=1.
- Invalid mode 2'b11 with req_valid. Expect:
  - resp_valid 1 cycle after accept, err=1, data=key=0.
  - core_rst_n and core_bgn never toggle; job_count unchanged.
- Decrypt req (mode 10), core gives only data_done=16'h36CB and no key strobe. Expect resp_err=1 exactly TIMEOUT cycles after WAIT entry, resp_data=36CB, resp_key=0.
- resp_ready held 0 for 20 cycles with repeat core strobes carrying other values. Expect:
  - resp_* stable throughout; req_ready=0; a new req_valid is not accepted.
  - Accept occurs the cycle after the resp handshake.
- rst asserted for 1 cycle mid-WAIT. Expect all outputs at reset values next cycle, no response, job_count=0; a following request completes normally.
- Data and key strobes in the same cycle, also issued during START. Expect both captured, RESP entered the next cycle, err=0. 256 back-to-back good jobs wrap job_count to 0.

Source files
------------

// File: rtl/crypto_host_ctrl.sv
// Host-side sequencer for the 16-bit crypto core: accepts one job, resets and starts the core,
// collects the data/key results and returns them, with a watchdog that turns a hung core into an error.
module crypto_host_ctrl #(
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned BGN_CYCLES = 10,
    parameter int unsigned TIMEOUT    = 200
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_mode,
    input  logic [15:0] i_req_data,
    input  logic [15:0] i_req_key,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [15:0] o_resp_data,
    output logic [15:0] o_resp_key,
    output logic        o_resp_err,
    output logic        o_core_rst_n,
    output logic        o_core_bgn,
    output logic [1:0]  o_core_mode,
    output logic [15:0] o_core_data,
    output logic [15:0] o_core_key,
    input  logic        i_core_data_done,
    input  logic        i_core_key_done,
    input  logic [15:0] i_core_data_out,
    input  logic [15:0] i_core_key_out,
    output logic        o_busy,
    output logic [7:0]  o_job_count
);

    typedef enum logic [2:0] {StIdle, StClr, StStart, StWait, StResp} state_e;

    localparam logic [7:0]  ClrLast  = 8'(CLR_CYCLES - 1);
    localparam logic [7:0]  BgnLast  = 8'(BGN_CYCLES - 1);
    localparam logic [15:0] WdogLast = 16'(TIMEOUT - 1);

    state_e      r_state, w_state_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic [15:0] r_wdog, w_wdog_d;
    logic        r_dflag, w_dflag_d;
    logic        r_kflag, w_kflag_d;
    logic [15:0] r_resp_data, w_resp_data_d;
    logic [15:0] r_resp_key, w_resp_key_d;
    logic        r_resp_err, w_resp_err_d;
    logic [1:0]  r_core_mode, w_core_mode_d;
    logic [15:0] r_core_data, w_core_data_d;
    logic [15:0] r_core_key, w_core_key_d;
    logic [7:0]  r_job_count, w_job_count_d;
    logic        r_req_ready, r_resp_valid, r_core_rst_n, r_core_bgn, r_busy;
    logic        w_both_done;

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_wdog_d       = r_wdog;
        w_dflag_d      = r_dflag;
        w_kflag_d      = r_kflag;
        w_resp_data_d  = r_resp_data;
        w_resp_key_d   = r_resp_key;
        w_resp_err_d   = r_resp_err;
        w_core_mode_d  = r_core_mode;
        w_core_data_d  = r_core_data;
        w_core_key_d   = r_core_key;
        w_job_count_d  = r_job_count;
        w_both_done    = (r_dflag | i_core_data_done) & (r_kflag | i_core_key_done);

        // First strobe of each kind wins; the core may finish while core_bgn is still high
        if (r_state == StStart || r_state == StWait) begin
            if (i_core_data_done && !r_dflag) begin
                w_resp_data_d = i_core_data_out;
                w_dflag_d     = 1'b1;
            end
            if (i_core_key_done && !r_kflag) begin
                w_resp_key_d = i_core_key_out;
                w_kflag_d    = 1'b1;
            end
        end

        case (r_state)
            StIdle: begin
                if (i_req_valid && r_req_ready) begin
                    w_core_mode_d = i_req_mode;
                    w_core_data_d = i_req_data;
                    w_core_key_d  = i_req_key;
                    w_resp_data_d = 16'h0;
                    w_resp_key_d  = 16'h0;
                    w_dflag_d     = 1'b0;
                    w_kflag_d     = 1'b0;
                    w_cnt_d       = 8'h0;
                    if (i_req_mode == 2'b01 || i_req_mode == 2'b10) begin
                        w_resp_err_d = 1'b0;
                        w_state_d    = StClr;
                    end else begin
                        w_resp_err_d = 1'b1;
                        w_state_d    = StResp;
                    end
                end
            end
            StClr: begin
                if (r_cnt == ClrLast) begin
                    w_cnt_d   = 8'h0;
                    w_dflag_d = 1'b0;
                    w_kflag_d = 1'b0;
                    w_state_d = StStart;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StStart: begin
                if (r_cnt == BgnLast) begin
                    w_cnt_d   = 8'h0;
                    w_wdog_d  = 16'h0;
                    w_state_d = StWait;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StWait: begin
                w_wdog_d = r_wdog + 16'd1;
                if (w_both_done) begin
                    w_resp_err_d = 1'b0;
                    w_state_d    = StResp;
                end else if (r_wdog == WdogLast) begin
                    w_resp_err_d = 1'b1;
                    w_state_d    = StResp;
                end
            end
            StResp: begin
                if (r_resp_valid && i_resp_ready) begin
                    w_state_d = StIdle;
                    if (!r_resp_err) begin
                        w_job_count_d = r_job_count + 8'd1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Status outputs are registered copies decoded from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= 8'h0;
            r_wdog       <= 16'h0;
            r_dflag      <= 1'b0;
            r_kflag      <= 1'b0;
            r_resp_data  <= 16'h0;
            r_resp_key   <= 16'h0;
            r_resp_err   <= 1'b0;
            r_core_mode  <= 2'b00;
            r_core_data  <= 16'h0;
            r_core_key   <= 16'h0;
            r_job_count  <= 8'h0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_core_rst_n <= 1'b1;
            r_core_bgn   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_wdog       <= w_wdog_d;
            r_dflag      <= w_dflag_d;
            r_kflag      <= w_kflag_d;
            r_resp_data  <= w_resp_data_d;
            r_resp_key   <= w_resp_key_d;
            r_resp_err   <= w_resp_err_d;
            r_core_mode  <= w_core_mode_d;
            r_core_data  <= w_core_data_d;
            r_core_key   <= w_core_key_d;
            r_job_count  <= w_job_count_d;
            r_req_ready  <= (w_state_d == StIdle);
            r_resp_valid <= (w_state_d == StResp);
            r_core_rst_n <= (w_state_d != StClr);
            r_core_bgn   <= (w_state_d == StStart);
            r_busy       <= (w_state_d != StIdle);
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_resp_key   = r_resp_key;
    assign o_resp_err   = r_resp_err;
    assign o_core_rst_n = r_core_rst_n;
    assign o_core_bgn   = r_core_bgn;
    assign o_core_mode  = r_core_mode;
    assign o_core_data  = r_core_data;
    assign o_core_key   = r_core_key;
    assign o_busy       = r_busy;
    assign o_job_count  = r_job_count;

endmodule

// File: tb/tb_crypto_host_ctrl.sv
// Self-checking bench for crypto_host_ctrl: table of jobs with a behavioural core model,
// a response scoreboard, and hand-written hold, reset and wrap sequences.
module tb_crypto_host_ctrl;

    localparam int TIMEOUT = 200;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [1:0]  i_req_mode = 2'b00;
    logic [15:0] i_req_data = 16'h0;
    logic [15:0] i_req_key = 16'h0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b0;
    logic [15:0] o_resp_data;
    logic [15:0] o_resp_key;
    logic        o_resp_err;
    logic        o_core_rst_n;
    logic        o_core_bgn;
    logic [1:0]  o_core_mode;
    logic [15:0] o_core_data;
    logic [15:0] o_core_key;
    logic        i_core_data_done = 1'b0;
    logic        i_core_key_done = 1'b0;
    logic [15:0] i_core_data_out = 16'h0;
    logic [15:0] i_core_key_out = 16'h0;
    logic        o_busy;
    logic [7:0]  o_job_count;

    crypto_host_ctrl #(
        .CLR_CYCLES(2),
        .BGN_CYCLES(10),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_mode      (i_req_mode),
        .i_req_data      (i_req_data),
        .i_req_key       (i_req_key),
        .o_resp_valid    (o_resp_valid),
        .i_resp_ready    (i_resp_ready),
        .o_resp_data     (o_resp_data),
        .o_resp_key      (o_resp_key),
        .o_resp_err      (o_resp_err),
        .o_core_rst_n    (o_core_rst_n),
        .o_core_bgn      (o_core_bgn),
        .o_core_mode     (o_core_mode),
        .o_core_data     (o_core_data),
        .o_core_key      (o_core_key),
        .i_core_data_done(i_core_data_done),
        .i_core_key_done (i_core_key_done),
        .i_core_data_out (i_core_data_out),
        .i_core_key_out  (i_core_key_out),
        .o_busy          (o_busy),
        .o_job_count     (o_job_count)
    );

    always #5 i_clk = ~i_clk;

    typedef enum int {KBad, KSeq, KDataOnly, KStart, KSame, KNone} kind_e;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic [15:0] key;
        kind_e       kind;
        logic [15:0] cdata;
        logic [15:0] ckey;
        logic [15:0] exp_data;
        logic [15:0] exp_key;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] k;
        logic        e;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] exp_count = 8'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    function automatic int exp_lat(input kind_e k);
        case (k)
            KSeq:            return 4;
            KDataOnly, KNone: return TIMEOUT;
            default:         return 1;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(o_resp_valid), 32'd0);
        check({tag, "_resp_data"}, 32'(o_resp_data), 32'd0);
        check({tag, "_resp_key"}, 32'(o_resp_key), 32'd0);
        check({tag, "_resp_err"}, 32'(o_resp_err), 32'd0);
        check({tag, "_core_rst_n"}, 32'(o_core_rst_n), 32'd1);
        check({tag, "_core_bgn"}, 32'(o_core_bgn), 32'd0);
        check({tag, "_core_mode"}, 32'(o_core_mode), 32'd0);
        check({tag, "_core_data"}, 32'(o_core_data), 32'd0);
        check({tag, "_core_key"}, 32'(o_core_key), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_job_count"}, 32'(o_job_count), 32'd0);
    endtask

    // Scoreboard: compare each response at its handshake edge
    always @(posedge i_clk) begin
        if (o_resp_valid === 1'b1 && i_resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: got data %h key %h err %b, expected no response",
                         o_resp_data, o_resp_key, o_resp_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_data", 32'(o_resp_data), 32'(mon_e.d));
                check("resp_key", 32'(o_resp_key), 32'(mon_e.k));
                check("resp_err", 32'(o_resp_err), 32'(mon_e.e));
            end
        end
    end

    task automatic run_job(input vec_t v, input int hold);
        int n;
        int w_start;
        n = 0;
        while (o_req_ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check("req_ready_idle", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_req_mode  = v.mode;
        i_req_data  = v.data;
        i_req_key   = v.key;
        exp_q.push_back('{d: v.exp_data, k: v.exp_key, e: v.exp_err});
        step();
        i_req_valid = 1'b0;
        check("busy_after_accept", 32'(o_busy), 32'd1);
        check("core_data_latch", 32'(o_core_data), 32'(v.data));
        check("core_key_latch", 32'(o_core_key), 32'(v.key));
        check("core_mode_latch", 32'(o_core_mode), 32'(v.mode));
        i_core_data_out = v.cdata;
        i_core_key_out  = v.ckey;
        if (v.kind == KBad) begin
            check("bad_resp_valid", 32'(o_resp_valid), 32'd1);
            check("bad_core_rst_n", 32'(o_core_rst_n), 32'd1);
            check("bad_core_bgn", 32'(o_core_bgn), 32'd0);
        end else begin
            n = 0;
            while (o_core_rst_n === 1'b0 && n < 50) begin
                step();
                n++;
            end
            check("clr_cycles", 32'(n), 32'd2);
            n = 0;
            while (o_core_bgn === 1'b1 && n < 300) begin
                i_core_data_done = (v.kind == KStart && n == 3);
                i_core_key_done  = (v.kind == KStart && n == 3);
                step();
                n++;
            end
            i_core_data_done = 1'b0;
            i_core_key_done  = 1'b0;
            check("bgn_cycles", 32'(n), 32'd10);
            w_start = cyc;
            case (v.kind)
                KSeq: begin
                    i_core_data_done = 1'b1;
                    step();
                    i_core_data_out = ~v.cdata;
                    step();
                    i_core_data_done = 1'b0;
                    step();
                    i_core_key_done = 1'b1;
                    step();
                    i_core_key_done = 1'b0;
                end
                KDataOnly: begin
                    i_core_data_done = 1'b1;
                    step();
                    i_core_data_done = 1'b0;
                end
                KSame: begin
                    i_core_data_done = 1'b1;
                    i_core_key_done  = 1'b1;
                    step();
                    i_core_data_done = 1'b0;
                    i_core_key_done  = 1'b0;
                end
                default: ;
            endcase
            while (o_resp_valid !== 1'b1 && cyc - w_start < TIMEOUT + 50) step();
            check("resp_latency", 32'(cyc - w_start), 32'(exp_lat(v.kind)));
        end
        if (hold > 0) begin
            i_req_valid = 1'b1;
            i_req_mode  = 2'b01;
            i_req_data  = 16'hC0DE;
            i_req_key   = 16'hBEEF;
            for (int i = 0; i < hold; i++) begin
                i_core_data_done = 1'b1;
                i_core_key_done  = 1'b1;
                i_core_data_out  = 16'hFFFF ^ 16'(i);
                i_core_key_out   = 16'hEEEE;
                step();
                check("hold_valid", 32'(o_resp_valid), 32'd1);
                check("hold_data", 32'(o_resp_data), 32'(v.exp_data));
                check("hold_key", 32'(o_resp_key), 32'(v.exp_key));
                check("hold_req_ready", 32'(o_req_ready), 32'd0);
            end
            i_core_data_done = 1'b0;
            i_core_key_done  = 1'b0;
        end
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;
        if (!v.exp_err) exp_count = exp_count + 8'd1;
        check("job_count", 32'(o_job_count), 32'(exp_count));
    endtask

    vec_t vecs[7];
    vec_t hv;
    vec_t rv;

    initial begin
        vecs[0] = '{2'b01, 16'h59B3, 16'h1325, KSeq, 16'h6A21, 16'hB4C7, 16'h6A21, 16'hB4C7, 1'b0};
        vecs[1] = '{2'b11, 16'h1111, 16'h2222, KBad, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1};
        vecs[2] = '{2'b10, 16'hAAAA, 16'h5555, KDataOnly, 16'h36CB, 16'h7777, 16'h36CB, 16'h0, 1'b1};
        vecs[3] = '{2'b00, 16'h3333, 16'h4444, KBad, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1};
        vecs[4] = '{2'b10, 16'h0102, 16'h0304, KSame, 16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A, 1'b0};
        vecs[5] = '{2'b01, 16'h1234, 16'h5678, KStart, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 1'b0};
        vecs[6] = '{2'b01, 16'h9999, 16'h8888, KNone, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1};
        hv      = '{2'b01, 16'h0F0F, 16'hF0F0, KSeq, 16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b0};

        repeat (3) step();
        i_rst = 1'b0;
        check_reset("rst");

        for (int i = 0; i < 7; i++) run_job(vecs[i], 0);

        // Response held off: no accept until the cycle after the handshake
        run_job(hv, 20);
        check("hs_req_ready", 32'(o_req_ready), 32'd1);
        check("hs_core_data_old", 32'(o_core_data), 32'h0F0F);
        step();
        i_req_valid = 1'b0;
        check("accept_core_data", 32'(o_core_data), 32'hC0DE);
        check("accept_busy", 32'(o_busy), 32'd1);

        // Reset during WAIT abandons the job silently
        for (int n = 0; n < 100 && o_core_bgn !== 1'b1; n++) step();
        for (int n = 0; n < 100 && o_core_bgn === 1'b1; n++) step();
        repeat (5) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        exp_count = 8'h0;
        check_reset("midrst");
        repeat (10) step();
        check("midrst_no_resp", 32'(o_resp_valid), 32'd0);
        run_job(vecs[0], 0);

        // 256 good jobs from reset wrap the counter back to zero
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        exp_count = 8'h0;
        for (int i = 0; i < 256; i++) begin
            rv.mode     = (i % 2 == 0) ? 2'b01 : 2'b10;
            rv.data     = 16'($urandom);
            rv.key      = 16'($urandom);
            rv.kind     = KSame;
            rv.cdata    = 16'($urandom);
            rv.ckey     = 16'($urandom);
            rv.exp_data = rv.cdata;
            rv.exp_key  = rv.ckey;
            rv.exp_err  = 1'b0;
            run_job(rv, 0);
        end
        check("job_count_wrap", 32'(o_job_count), 32'd0);
        check("resp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
